alu_operand_loader: RTL and testbench

- Receive end of the 8-bit data bus that feeds the ALU. Assembles two 16-bit operands from byte transfers, high byte first.
- Issues a one-cycle start to the ALU and waits for completion.
- On completion, pulses grab so the ALU result latch captures the result. It is the write-side counterpart of the result latch's byte-wise read-out.

---
 rtl/alu_bus_pkg.sv | 25 ++
 rtl/alu_operand_loader_if.sv | 34 +++
 rtl/alu_wait_timer.sv | 31 +++
 rtl/alu_operand_loader.sv | 113 +++++++++++
 tb/tb_alu_operand_loader.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_bus_pkg.sv
// Shared ALU data-bus definitions: loader state encoding, bus/word widths, opcode width.
// Imported by the operand loader, its wait timer and the ALU-side result latch.
package alu_bus_pkg;

  localparam int BYTE_W          = 8;
  localparam int WORD_W          = 16;
  localparam int OPW             = 4;
  localparam int TIMEOUT_DEFAULT = 64;
  localparam int TMR_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_HI,
    ST_A_LO,
    ST_B_HI,
    ST_B_LO,
    ST_ISSUE,
    ST_WAIT_ALU
  } ld_state_t;

  function automatic logic is_collecting(input ld_state_t s);
    return (s == ST_A_HI) || (s == ST_A_LO) || (s == ST_B_HI) || (s == ST_B_LO);
  endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Bus between the data-bus driver (master) and the ALU operand loader (slave).
// Carries the byte stream, the transaction controls and the assembled operands.
interface alu_operand_loader_if #(
  parameter int OPW = alu_bus_pkg::OPW
);
  import alu_bus_pkg::*;

  logic              start_load;
  logic              unary;
  logic [OPW-1:0]    opcode_in;
  logic              byte_valid;
  logic [BYTE_W-1:0] data_in;
  logic              abort;
  logic              alu_done;
  logic              byte_ready;
  logic [WORD_W-1:0] operand_a;
  logic [WORD_W-1:0] operand_b;
  logic [OPW-1:0]    opcode_out;
  logic              alu_start;
  logic              grab;
  logic              busy;
  logic              error;

  modport master (
    output start_load, unary, opcode_in, byte_valid, data_in, abort, alu_done,
    input  byte_ready, operand_a, operand_b, opcode_out, alu_start, grab, busy, error
  );

  modport slave (
    input  start_load, unary, opcode_in, byte_valid, data_in, abort, alu_done,
    output byte_ready, operand_a, operand_b, opcode_out, alu_start, grab, busy, error
  );

endinterface

// File: rtl/alu_wait_timer.sv
// WAIT_ALU cycle counter: cleared in ISSUE, counts while enabled, flags the last allowed wait cycle.
// expired is combinational from the count; no backpressure.
module alu_wait_timer
  import alu_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The count reads 0 in the first wait cycle, i.e. one behind the cycles elapsed since
  // alu_start, so the final wait cycle (TIMEOUT-1 cycles after alu_start) sees TIMEOUT-2.
  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 2);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/alu_operand_loader.sv
// Assembles two 16-bit ALU operands from high-byte-first bus transfers, launches the ALU, pulses grab on done.
// alu_start one cycle after the last byte, grab one cycle after alu_done; byte_ready throttles the byte stream.
module alu_operand_loader
  import alu_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int OPW     = alu_bus_pkg::OPW
) (
  input logic                 clock,
  input logic                 reset,
  alu_operand_loader_if.slave bus
);

  ld_state_t         state;
  ld_state_t         state_nxt;
  logic              unary_q;
  logic [WORD_W-1:0] opa_q;
  logic [WORD_W-1:0] opb_q;
  logic [OPW-1:0]    opc_q;
  logic              grab_q;
  logic              error_q;
  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_expired;
  logic              take_byte;
  logic              take_load;

  alu_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (bus.start_load) state_nxt = ST_A_HI;
        ST_A_HI:     if (bus.byte_valid) state_nxt = ST_A_LO;
        ST_A_LO:     if (bus.byte_valid) state_nxt = unary_q ? ST_ISSUE : ST_B_HI;
        ST_B_HI:     if (bus.byte_valid) state_nxt = ST_B_LO;
        ST_B_LO:     if (bus.byte_valid) state_nxt = ST_ISSUE;
        ST_ISSUE:    state_nxt = ST_WAIT_ALU;
        ST_WAIT_ALU: if (bus.alu_done || tmr_expired) state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.byte_ready = is_collecting(state);
    bus.busy       = (state != ST_IDLE);
    bus.alu_start  = (state == ST_ISSUE) && !bus.abort;
    tmr_clear      = (state == ST_ISSUE);
    tmr_en         = (state == ST_WAIT_ALU);
  end

  assign take_byte = is_collecting(state) && bus.byte_valid && !bus.abort;
  assign take_load = (state == ST_IDLE) && bus.start_load && !bus.abort;

  always_ff @(posedge clock) begin
    if (!reset) begin
      unary_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      grab_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      grab_q <= (state == ST_WAIT_ALU) && bus.alu_done && !bus.abort;
      if (take_load) begin
        opc_q   <= bus.opcode_in;
        unary_q <= bus.unary;
        opb_q   <= '0;
        error_q <= 1'b0;
      end
      // alu_done on the expiry cycle wins over the timeout
      if ((state == ST_WAIT_ALU) && tmr_expired && !bus.alu_done && !bus.abort) begin
        error_q <= 1'b1;
      end
      if (take_byte) begin
        case (state)
          ST_A_HI: opa_q[WORD_W-1:BYTE_W] <= bus.data_in;
          ST_A_LO: opa_q[BYTE_W-1:0]      <= bus.data_in;
          ST_B_HI: opb_q[WORD_W-1:BYTE_W] <= bus.data_in;
          ST_B_LO: opb_q[BYTE_W-1:0]      <= bus.data_in;
          default: ;
        endcase
      end
    end
  end

  assign bus.operand_a  = opa_q;
  assign bus.operand_b  = opb_q;
  assign bus.opcode_out = opc_q;
  assign bus.grab       = grab_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed scenarios then random traffic, each cycle compared
// against a transaction-level model of the loader (byte count, cycles since launch).
module tb_alu_operand_loader;

  localparam int TO = 8;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_ISSUE = 2;
  localparam int M_WAIT  = 3;

  logic clock;
  logic reset;

  alu_operand_loader_if #(.OPW(4)) bus ();

  alu_operand_loader #(
    .TIMEOUT(TO),
    .OPW    (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  int          m_mode;
  int          m_nb;
  int          m_cyc;
  int          m_iss;
  logic        m_un;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [3:0]  m_op;
  logic        m_err;
  logic        m_grab;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_ctl();
    return {bus.byte_ready, bus.busy, bus.alu_start, bus.grab, bus.error};
  endfunction

  task automatic model_tick(input logic sl, input logic un, input logic [3:0] op,
                            input logic bv, input logic [7:0] d, input logic ab,
                            input logic dn, input logic rs);
    logic g;
    g = 1'b0;
    if (!rs) begin
      m_mode = M_IDLE; m_nb = 0; m_un = 1'b0;
      m_a = '0; m_b = '0; m_op = '0; m_err = 1'b0; m_grab = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (sl && !ab) begin
          m_mode = M_LOAD; m_nb = 0; m_op = op; m_un = un; m_err = 1'b0; m_b = '0;
        end
        M_LOAD: if (ab) m_mode = M_IDLE;
          else if (bv) begin
            case (m_nb)
              0:       m_a = (m_a & 16'h00FF) | {d, 8'h00};
              1:       m_a = (m_a & 16'hFF00) | {8'h00, d};
              2:       m_b = (m_b & 16'h00FF) | {d, 8'h00};
              default: m_b = (m_b & 16'hFF00) | {8'h00, d};
            endcase
            m_nb++;
            if (m_nb == (m_un ? 2 : 4)) m_mode = M_ISSUE;
          end
        M_ISSUE: if (ab) m_mode = M_IDLE;
          else begin m_iss = m_cyc; m_mode = M_WAIT; end
        default: if (ab) m_mode = M_IDLE;
          else if (dn) begin g = 1'b1; m_mode = M_IDLE; end
          else if (m_cyc - m_iss == TO - 1) begin m_err = 1'b1; m_mode = M_IDLE; end
      endcase
      m_grab = g;
    end
    m_cyc++;
  endtask

  task automatic step(input logic sl, input logic un, input logic [3:0] op,
                      input logic bv, input logic [7:0] d, input logic ab,
                      input logic dn, input logic rs);
    logic [4:0] exp_ctl;
    bus.start_load = sl; bus.unary = un; bus.opcode_in = op;
    bus.byte_valid = bv; bus.data_in = d; bus.abort = ab; bus.alu_done = dn;
    reset = rs;
    #1;
    exp_ctl = {m_mode == M_LOAD, m_mode != M_IDLE, (m_mode == M_ISSUE) && !ab, m_grab, m_err};
    chk("ctl", 32'(dut_ctl()), 32'(exp_ctl));
    chk("opa", 32'(bus.operand_a), 32'(m_a));
    chk("opb", 32'(bus.operand_b), 32'(m_b));
    chk("opc", 32'(bus.opcode_out), 32'(m_op));
    @(posedge clock);
    model_tick(sl, un, op, bv, d, ab, dn, rs);
    @(negedge clock);
    bus.start_load = 1'b0; bus.byte_valid = 1'b0; bus.abort = 1'b0; bus.alu_done = 1'b0;
    reset = 1'b1;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic load(input logic un, input logic [3:0] op);
    step(1'b1, un, op, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic put(input logic [7:0] d);
    step(1'b0, 1'b0, 4'h0, 1'b1, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic done();
    step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    m_cyc = 0; m_iss = 0;
    reset = 1'b0;
    bus.start_load = 1'b0; bus.unary = 1'b0; bus.opcode_in = '0;
    bus.byte_valid = 1'b0; bus.data_in = '0; bus.abort = 1'b0; bus.alu_done = 1'b0;
    repeat (2) @(posedge clock);
    model_tick(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_ctl", 32'(dut_ctl()), 32'h0);
    chk("rst_opa", 32'(bus.operand_a), 32'h0);
    chk("rst_opc", 32'(bus.opcode_out), 32'h0);

    // binary op, bytes back to back; a byte offered with start_load is dropped
    step(1'b1, 1'b0, 4'h3, 1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    put(8'h12); put(8'h34); put(8'hAB); put(8'hCD);
    chk("bin_start", 32'(bus.alu_start), 32'h1);
    chk("bin_opa", 32'(bus.operand_a), 32'h1234);
    chk("bin_opb", 32'(bus.operand_b), 32'hABCD);
    chk("bin_opc", 32'(bus.opcode_out), 32'h3);
    idle(); idle(); idle(); done();
    chk("bin_grab", 32'({bus.grab, bus.busy, bus.error}), 32'b100);

    // unary op with a 5-cycle gap between bytes
    load(1'b1, 4'h5);
    put(8'hFF);
    repeat (5) idle();
    chk("un_wait_rdy", 32'(bus.byte_ready), 32'h1);
    put(8'h01);
    chk("un_start", 32'({bus.alu_start, bus.byte_ready}), 32'b10);
    chk("un_opa", 32'(bus.operand_a), 32'hFF01);
    chk("un_opb", 32'(bus.operand_b), 32'h0000);
    idle(); done();

    // timeout: no alu_done, abandon TO cycles after alu_start
    load(1'b1, 4'h7); put(8'h55); put(8'hAA);
    chk("to_start", 32'(bus.alu_start), 32'h1);
    repeat (TO - 1) idle();
    chk("to_still_busy", 32'({bus.busy, bus.error}), 32'b10);
    idle();
    chk("to_expired", 32'({bus.busy, bus.error, bus.grab}), 32'b010);
    load(1'b0, 4'h9);
    chk("to_err_clr", 32'({bus.busy, bus.error}), 32'b10);

    // abort in B_LO, with a byte offered at the same time
    put(8'h5A); put(8'hC3); put(8'h77);
    step(1'b0, 1'b0, 4'h0, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    chk("ab_idle", 32'(bus.busy), 32'h0);
    chk("ab_opa", 32'(bus.operand_a), 32'h5AC3);
    chk("ab_opb", 32'(bus.operand_b), 32'h7700);
    idle();
    chk("ab_nograb", 32'({bus.grab, bus.alu_start}), 32'b00);

    // stray byte_valid / alu_done in IDLE, and start_load with abort
    step(1'b0, 1'b0, 4'h0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    chk("stray_idle", 32'({bus.busy, bus.grab}), 32'b00);
    chk("stray_opa", 32'(bus.operand_a), 32'h5AC3);
    step(1'b1, 1'b0, 4'hF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("ab_in_idle", 32'(bus.busy), 32'h0);

    // alu_done on the expiry cycle counts as done
    load(1'b1, 4'h2); put(8'h10); put(8'h20);
    repeat (TO - 1) idle();
    done();
    chk("exp_done", 32'({bus.grab, bus.error, bus.busy}), 32'b100);
    load(1'b0, 4'h4);
    chk("relaunch_on_grab", 32'(bus.busy), 32'h1);

    // reset during WAIT_ALU, then a late alu_done
    put(8'h01); put(8'h02); put(8'h03); put(8'h04); idle();
    step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mrst_ctl", 32'(dut_ctl()), 32'h0);
    chk("mrst_ops", {bus.operand_a, bus.operand_b}, 32'h0);
    done();
    chk("mrst_nograb", 32'({bus.grab, bus.busy}), 32'b00);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom), 4'($urandom),
           $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 40) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 300) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
